// File: rtl/alu_2_15_seq.sv
// Registered five-operation integer ALU: WIDTH-bit unsigned operands in, a 2*WIDTH-bit
// result with a valid flag one clock after each accepted input.
module alu_2_15_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [2:0]         control,
    input  logic [WIDTH-1:0]   in_data1,
    input  logic [WIDTH-1:0]   in_data2,
    output logic [2*WIDTH-1:0] out_data,
    output logic               out_valid
);

    localparam int RW = 2 * WIDTH;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_NOR = 3'd4
    } alu_op_e;

    typedef struct packed {
        logic [RW-1:0] data;
        logic          valid;
    } alu_rsp_t;

    logic [RW-1:0] a_ext, b_ext;
    logic [RW-1:0] result;
    alu_rsp_t      rsp_d, rsp_q;

    assign a_ext = {{WIDTH{1'b0}}, in_data1};
    assign b_ext = {{WIDTH{1'b0}}, in_data2};

    // Everything is evaluated at 2*WIDTH so ADD's carry and SUB's wrap fall out naturally;
    // the bitwise ops are built on the narrow operands to keep the upper half zero.
    always_comb begin
        result = '0;
        case (control)
            OP_ADD:  result = a_ext + b_ext;
            OP_SUB:  result = a_ext - b_ext;
            OP_MUL:  result = a_ext * b_ext;
            OP_AND:  result = {{WIDTH{1'b0}}, in_data1 & in_data2};
            OP_NOR:  result = {{WIDTH{1'b0}}, ~(in_data1 | in_data2)};
            default: result = '0;
        endcase
    end

    always_comb begin
        rsp_d       = rsp_q;
        rsp_d.valid = in_valid;
        if (in_valid) begin
            rsp_d.data = result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q <= '0;
        end else begin
            rsp_q <= rsp_d;
        end
    end

    assign out_data  = rsp_q.data;
    assign out_valid = rsp_q.valid;

endmodule

// File: tb/tb_alu_2_15_seq.sv
// Scoreboarded bench for alu_2_15_seq: directed vectors with hand-computed results,
// reset/hold behaviour, and a full operand/opcode sweep against a small reference model.
module tb_alu_2_15_seq;

    localparam int W = 4;

    typedef struct {
        logic [2*W-1:0] data;
        int             due;
        string          tag;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           in_valid = 1'b0;
    logic [2:0]     control = '0;
    logic [W-1:0]   in_data1 = '0;
    logic [W-1:0]   in_data2 = '0;
    logic [2*W-1:0] out_data;
    logic           out_valid;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    alu_2_15_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .control  (control),
        .in_data1 (in_data1),
        .in_data2 (in_data2),
        .out_data (out_data),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*W-1:0] ref_model(input logic [2:0] c, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        int ai, bi, r;
        ai = int'(a);
        bi = int'(b);
        case (c)
            3'd0:    r = ai + bi;
            3'd1:    r = ai - bi + 256;
            3'd2:    r = ai * bi;
            3'd3:    r = ai & bi;
            3'd4:    r = 15 - (ai | bi);
            default: r = 0;
        endcase
        return 8'(r % 256);
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one operation (called right after a rising edge) and queue its expected result.
    task automatic issue(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp, input string tag);
        exp_t e;
        in_valid = 1'b1;
        control  = c;
        in_data1 = a;
        in_data2 = b;
        e.data = exp;
        e.due  = cyc + 1;
        e.tag  = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input int n, input logic [2*W-1:0] exp_data, input string tag);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            check({tag, " out_valid"}, {7'd0, out_valid}, 8'h00);
            check({tag, " out_data"}, out_data, exp_data);
        end
    endtask

    // Monitor: every valid output must match the head of the queue, on its due cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                check({e.tag, " valid"}, {7'd0, out_valid}, 8'h01);
                check(e.tag, out_data, e.data);
            end else if (q.size() > 0 && q[0].due < cyc) begin
                exp_t e;
                e = q.pop_front();
                n_vec++;
                n_bad++;
                $display("FAIL %s: result overdue, due cycle %0d now %0d", e.tag, e.due, cyc);
            end else if (out_valid) begin
                n_vec++;
                n_bad++;
                $display("FAIL spurious out_valid: data %h with no pending vector", out_data);
            end
        end
    end

    typedef struct {
        logic [2:0]     c;
        logic [W-1:0]   a, b;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t dir[$] = '{
        '{3'd0, 4'hF, 4'hF, 8'h1E},
        '{3'd2, 4'hF, 4'hF, 8'hE1},
        '{3'd3, 4'hF, 4'hF, 8'h0F},
        '{3'd4, 4'hF, 4'hF, 8'h00},
        '{3'd1, 4'h1, 4'h2, 8'hFF},
        '{3'd1, 4'h9, 4'h3, 8'h06},
        '{3'd4, 4'h5, 4'h2, 8'h08},
        '{3'd5, 4'h5, 4'h2, 8'h00},
        '{3'd6, 4'h5, 4'h2, 8'h00},
        '{3'd7, 4'h5, 4'h2, 8'h00},
        '{3'd2, 4'h7, 4'h3, 8'h15},
        '{3'd0, 4'h9, 4'h8, 8'h11}
    };

    initial begin
        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("reset out_data", out_data, 8'h00);
        check("reset out_valid", {7'd0, out_valid}, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle_chk(3, 8'h00, "post-reset idle");

        foreach (dir[i])
            issue(dir[i].c, dir[i].a, dir[i].b, dir[i].exp, $sformatf("dir%0d ctl%0d", i, dir[i].c));

        // Single-cycle pulse then hold.
        issue(3'd0, 4'h3, 4'h4, 8'h07, "pulse add");
        idle_chk(3, 8'h07, "hold");

        // Reset in the middle of a back-to-back burst.
        issue(3'd2, 4'h6, 4'h5, 8'h1E, "burst0");
        issue(3'd3, 4'hC, 4'hA, 8'h08, "burst1");
        in_valid = 1'b1;
        control  = 3'd0;
        in_data1 = 4'h2;
        in_data2 = 4'h2;
        #2 rst_n = 1'b0;
        #1;
        check("midreset out_data", out_data, 8'h00);
        check("midreset out_valid", {7'd0, out_valid}, 8'h00);
        q.delete();
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle_chk(3, 8'h00, "post-midreset idle");

        // Full sweep, back to back.
        for (int c = 0; c < 8; c++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    issue(3'(c), 4'(a), 4'(b), ref_model(3'(c), 4'(a), 4'(b)),
                          $sformatf("sweep c%0d a%0d b%0d", c, a, b));
        idle_chk(2, ref_model(3'd7, 4'hF, 4'hF), "final idle");

        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d results never appeared, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
